// File: rtl/fluxo_ram_mem.sv
// Single-port matrix storage RAM with a registered, write-first read port.
// Each word has a valid bit, so reset clears the whole array in one edge without touching the data.
module fluxo_ram_mem #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] endereco,
  input  logic [DATA_WIDTH-1:0] dado_entrada,
  input  logic                  grava,
  output logic [DATA_WIDTH-1:0] dado_saida
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0]      word_vld;
  logic [DATA_WIDTH-1:0] rd_data_p1;

  function automatic logic [DATA_WIDTH-1:0] mask_word(input logic vld,
                                                      input logic [DATA_WIDTH-1:0] word);
    return vld ? word : '0;
  endfunction

  // The array has no reset. A write that lands while reset is high is harmless,
  // because the valid bit for that word stays clear and masks the stored value.
  always_ff @(posedge clk) begin
    if (grava)
      mem[endereco] <= dado_entrada;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      word_vld <= '0;
    else if (grava)
      word_vld[endereco] <= 1'b1;
  end

  // stage p1: registered output, write-first on write cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_data_p1 <= '0;
    else if (grava)
      rd_data_p1 <= dado_entrada;
    else
      rd_data_p1 <= mask_word(word_vld[endereco], mem[endereco]);
  end

  assign dado_saida = rd_data_p1;

endmodule

// File: tb/tb_fluxo_ram_mem.sv
// Directed bench for fluxo_ram_mem. Expected values are hand-computed constants and loop indices.
module tb_fluxo_ram_mem;

  logic       clk;
  logic       reset;
  logic [7:0] endereco;
  logic [8:0] dado_entrada;
  logic       grava;
  logic [8:0] dado_saida;

  int checks;
  int errors;

  fluxo_ram_mem dut (
    .clk          (clk),
    .reset        (reset),
    .endereco     (endereco),
    .dado_entrada (dado_entrada),
    .grava        (grava),
    .dado_saida   (dado_saida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Drive one access, let it take the next rising edge, then return 1 time unit after it.
  task automatic access(input logic wr, input logic [7:0] addr, input logic [8:0] data);
    grava        = wr;
    endereco     = addr;
    dado_entrada = data;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    reset        = 1'b1;
    grava        = 1'b0;
    endereco     = '0;
    dado_entrada = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", dado_saida, 9'd0);
    reset = 1'b0;

    // Fresh memory reads as zero
    access(1'b0, 8'd0,   9'd0); chk("rd_empty_0",   dado_saida, 9'd0);
    access(1'b0, 8'd24,  9'd0); chk("rd_empty_24",  dado_saida, 9'd0);
    access(1'b0, 8'd255, 9'd0); chk("rd_empty_255", dado_saida, 9'd0);

    // Width and address boundaries
    access(1'b1, 8'd255, 9'h1FF); chk("wr_255_echo", dado_saida, 9'h1FF);
    access(1'b1, 8'd0,   9'h100); chk("wr_0_echo",   dado_saida, 9'h100);
    access(1'b0, 8'd255, 9'd0);   chk("rd_255",      dado_saida, 9'h1FF);
    access(1'b0, 8'd0,   9'd0);   chk("rd_0",        dado_saida, 9'h100);
    access(1'b0, 8'd254, 9'd0);   chk("rd_254_zero", dado_saida, 9'd0);
    access(1'b0, 8'd1,   9'd0);   chk("rd_1_zero",   dado_saida, 9'd0);

    // Sequential loader pattern: 1..25 into 0..24
    for (int i = 0; i < 25; i++) begin
      access(1'b1, 8'(i), 9'(i + 1));
      chk($sformatf("load_echo_%0d", i), dado_saida, 9'(i + 1));
    end
    for (int i = 0; i < 25; i++) begin
      access(1'b0, 8'(i), 9'd0);
      chk($sformatf("load_rd_%0d", i), dado_saida, 9'(i + 1));
    end

    // Overwrite: last write wins
    access(1'b1, 8'd10, 9'd7);   chk("ovw_echo_7",   dado_saida, 9'd7);
    access(1'b1, 8'd10, 9'd300); chk("ovw_echo_300", dado_saida, 9'd300);
    access(1'b0, 8'd10, 9'd0);   chk("ovw_rd_10",    dado_saida, 9'd300);

    // Read/write interleave
    access(1'b1, 8'd3, 9'd42); chk("ilv_wr_3", dado_saida, 9'd42);
    access(1'b0, 8'd3, 9'd0);  chk("ilv_rd_3", dado_saida, 9'd42);
    access(1'b1, 8'd4, 9'd5);  chk("ilv_wr_4", dado_saida, 9'd5);

    // Asynchronous reset mid-load
    access(1'b1, 8'd30, 9'd111); chk("mid_echo_30", dado_saida, 9'd111);
    access(1'b1, 8'd31, 9'd222); chk("mid_echo_31", dado_saida, 9'd222);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_out", dado_saida, 9'd0);
    access(1'b1, 8'd40, 9'h055); chk("rst_hold_wr", dado_saida, 9'd0);
    reset = 1'b0;
    access(1'b0, 8'd30, 9'd0);  chk("post_rst_30",  dado_saida, 9'd0);
    access(1'b0, 8'd31, 9'd0);  chk("post_rst_31",  dado_saida, 9'd0);
    access(1'b0, 8'd10, 9'd0);  chk("post_rst_10",  dado_saida, 9'd0);
    access(1'b0, 8'd255, 9'd0); chk("post_rst_255", dado_saida, 9'd0);
    access(1'b0, 8'd40, 9'd0);  chk("post_rst_40",  dado_saida, 9'd0);

    // Normal access resumes right after release
    access(1'b1, 8'd40, 9'd77); chk("resume_wr_40", dado_saida, 9'd77);
    access(1'b0, 8'd40, 9'd0);  chk("resume_rd_40", dado_saida, 9'd77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
